mem_arb: RTL

Single-port memory arbiter between the instruction-fetch requester and the data (load/store) requester of the pipeline. It grants one requester at a time onto the shared memory bus, sequences each access with a small FSM, returns read data with a one-cycle valid pulse, and drives the stall lines that freeze the fetch and memory stages while their access is outstanding. Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arb_if.sv | 46 ++++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_arb.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths, memory op codes, FSM state and grant types for the
// instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int MEM_OP_W = 3;
  localparam int STARVE_W = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE    = 3'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTE = 3'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALF = 3'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_WORD = 3'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_BYTE = 3'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_HALF = 3'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_WORD = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY_IF = 3'd1,
    ST_BUSY_D  = 3'd2,
    ST_DONE_IF = 3'd3,
    ST_DONE_D  = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_WR_BYTE) || (op == MEM_OP_WR_HALF) || (op == MEM_OP_WR_WORD);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-bus signals of the arbiter. master = arbiter side,
// slave = pipeline plus memory side.
interface mem_arb_if;
  import mem_arb_pkg::*;

  // Handshake: a requester raises req with stable address/op/data and holds
  // it until its one-cycle valid pulse; the memory ends a bus access by
  // raising i_mem_ready for one cycle while o_mem_req is high.
  logic                i_if_req;
  logic [ADDR_W-1:0]   i_if_addr;
  logic [WORD_W-1:0]   o_if_rdata;
  logic                o_if_valid;
  logic                o_stall_if;

  logic                i_d_req;
  logic [ADDR_W-1:0]   i_d_addr;
  logic [MEM_OP_W-1:0] i_d_op;
  logic [WORD_W-1:0]   i_d_wdata;
  logic [WORD_W-1:0]   o_d_rdata;
  logic                o_d_valid;
  logic                o_stall_d;

  logic                o_mem_req;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [MEM_OP_W-1:0] o_mem_op;
  logic [WORD_W-1:0]   o_mem_wdata;
  logic                i_mem_ready;
  logic [WORD_W-1:0]   i_mem_rdata;

  modport master (
    input  i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_op, i_d_wdata,
    input  i_mem_ready, i_mem_rdata,
    output o_if_rdata, o_if_valid, o_stall_if,
    output o_d_rdata, o_d_valid, o_stall_d,
    output o_mem_req, o_mem_addr, o_mem_op, o_mem_wdata
  );

  modport slave (
    output i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_op, i_d_wdata,
    output i_mem_ready, i_mem_rdata,
    input  o_if_rdata, o_if_valid, o_stall_if,
    input  o_d_rdata, o_d_valid, o_stall_d,
    input  o_mem_req, o_mem_addr, o_mem_op, o_mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection: data has priority unless fetch has waited through
// STARVE_MAX consecutive data grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output grant_e              grant_o
);

  always_comb begin
    grant_o = GNT_NONE;
    if (d_req_i && !(if_req_i && (starve_cnt_i == STARVE_W'(STARVE_MAX)))) begin
      grant_o = GNT_D;
    end else if (if_req_i) begin
      grant_o = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter: grants fetch or data onto the shared bus,
// sequences the access, pulses completion and drives the stage stalls.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                clr,
  mem_arb_if.master           bus,
  output arb_state_e          state_o,
  output logic [STARVE_W-1:0] starve_cnt_o
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MEM_OP_W-1:0] op_q, op_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
  logic [WORD_W-1:0]   d_rdata_q, d_rdata_d;
  grant_e              grant;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req_i     (bus.i_if_req),
    .d_req_i      (bus.i_d_req),
    .starve_cnt_i (starve_q),
    .grant_o      (grant)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        case (grant)
          GNT_IF: begin
            state_d  = ST_BUSY_IF;
            starve_d = '0;
            addr_d   = bus.i_if_addr;
            op_d     = MEM_OP_RD_WORD;
            wdata_d  = '0;
          end
          GNT_D: begin
            addr_d  = bus.i_d_addr;
            op_d    = bus.i_d_op;
            wdata_d = is_store(bus.i_d_op) ? bus.i_d_wdata : '0;
            if (bus.i_if_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
              starve_d = starve_q + STARVE_W'(1);
            end
            // A no-op data request completes without touching the bus.
            if (bus.i_d_op == MEM_OP_NONE) begin
              state_d   = ST_DONE_D;
              d_rdata_d = '0;
            end else begin
              state_d = ST_BUSY_D;
            end
          end
          default: ;
        endcase
      end
      ST_BUSY_IF: begin
        if (bus.i_mem_ready) begin
          if_rdata_d = bus.i_mem_rdata;
          state_d    = ST_DONE_IF;
        end
      end
      ST_BUSY_D: begin
        if (bus.i_mem_ready) begin
          d_rdata_d = bus.i_mem_rdata;
          state_d   = ST_DONE_D;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      op_q       <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.o_mem_req   = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_D);
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_op    = op_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_if_valid  = (state_q == ST_DONE_IF);
  assign bus.o_d_valid   = (state_q == ST_DONE_D);
  assign bus.o_stall_if  = bus.i_if_req && !bus.o_if_valid;
  assign bus.o_stall_d   = bus.i_d_req && !bus.o_d_valid;

  assign state_o      = state_q;
  assign starve_cnt_o = starve_q;

endmodule
